// File: rtl/pipe_pkg.sv
// Shared definitions for the redirect pipeline front end.
// Holds the PC step, reset/NOP constants, the fetch buffer entry type and a
// helper that forces an address onto a word boundary.
package pipe_pkg;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Two-entry skid buffer of fetched instructions.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, push_data: write one entry (caller guarantees space)
//   pop            : remove the head entry (ignored when empty)
//   flush          : drop all entries; wins over push and pop
//   count          : number of stored entries (0..2)
//   head           : oldest entry (cleared to zero by reset)
module ifetch_skid_fifo
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '{pc: 32'h0, instr: NOP_INSTR};
      mem_q[1] <= '{pc: 32'h0, instr: NOP_INSTR};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory, buffers returned words in a 2-entry skid
// FIFO and hands them to decode over a valid/ready handshake. A redirect
// flushes the buffer, bumps the epoch so stale responses are dropped, and
// restarts fetching at the (word-aligned) target.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   stall                       : blocks new memory requests only
//   redirect_valid, redirect_pc : taken branch/jump and its target
//   imem_req, imem_addr         : memory read request and word address
//   imem_rdata                  : data for the previous cycle's request
//   ir_valid, ir, ir_pc         : instruction to decode and its PC
//   ir_ready                    : decode accepts ir this cycle
//   misalign                    : one-cycle pulse after a misaligned target
module ifetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready,
  output logic        misalign
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         inflight_q, inflight_d;
  logic         epoch_q, epoch_d;
  logic         req_epoch_q, req_epoch_d;
  logic         misalign_q, misalign_d;
  // Goes high on the first edge after reset release so requests start on a
  // clean cycle boundary rather than the instant rst_n deasserts.
  logic         run_q;

  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;
  logic         push, pop, flush;
  logic [2:0]   occupancy;
  logic         issue;

  assign flush = redirect_valid;
  assign pop   = ir_valid && ir_ready && !redirect_valid;

  // Only responses belonging to the current epoch are kept; the flush
  // inside the FIFO additionally drops anything arriving during a redirect.
  assign push       = inflight_q && (req_epoch_q == epoch_q);
  assign push_entry = '{pc: req_addr_q, instr: imem_rdata};

  // Slots committed next cycle: stored entries plus the word in flight,
  // minus the entry leaving now. Counting the pop lets a full-rate stream
  // keep one request per cycle while never overfilling the buffer.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = run_q && !stall && !redirect_valid
                     && (occupancy < 3'(FIFO_DEPTH));

  always_comb begin
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q;
    inflight_d  = issue;
    misalign_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      pc_d    = align_word(redirect_pc);
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d        = pc_q + PC_STEP;
      req_addr_d  = pc_q;
      req_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_addr_q  <= 32'h0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      misalign_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      misalign_q  <= misalign_d;
      run_q       <= 1'b1;
    end
  end

  ifetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign ir_valid  = (fifo_count != 2'd0);
  assign ir        = fifo_head.instr;
  assign ir_pc     = fifo_head.pc;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready = 1'b0;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous memory: data appears the cycle after the request; garbage
  // otherwise so that an unrequested capture is visible.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memf(imem_addr);
    else          imem_rdata <= $urandom;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle window: inputs change right after the falling edge, outputs
  // are sampled 1 ns later, well before the next rising edge.
  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic rdy);
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_pc = rpc; ir_ready = rdy;
    #1;
  endtask

  // Leaves the bench in window W0 (reset just released, no request yet).
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    ir_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic        exp_mis;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } redir_vec_t;

  redir_vec_t rtab [5];

  initial begin
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        expect_empty;
    int          delivered;
    logic        st, rv, rdy;
    logic [31:0] rpc;

    rtab[0] = '{32'h0000_0100, 1'b0, 32'h0000_0100, 32'h0000_0104};
    rtab[1] = '{32'h0000_0203, 1'b1, 32'h0000_0200, 32'h0000_0204};
    rtab[2] = '{32'h0000_1001, 1'b1, 32'h0000_1000, 32'h0000_1004};
    rtab[3] = '{32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    rtab[4] = '{32'h0000_0040, 1'b0, 32'h0000_0040, 32'h0000_0044};

    // Reset state and first fetches at full rate
    do_reset(1'b1);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_pc", ir_pc, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    drive(0, 0, 0, 1);
    chk("w1_req", {31'b0, imem_req}, 32'd1);
    chk("w1_addr", imem_addr, 32'd0);
    drive(0, 0, 0, 1);
    chk("w2_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("w2_addr", imem_addr, 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1);
      chk("seq_valid", {31'b0, ir_valid}, 32'd1);
      chk("seq_pc", ir_pc, 32'(4 * k));
      chk("seq_ir", ir, memf(32'(4 * k)));
    end

    // Backpressure: buffer fills, requests stop, order preserved on release
    do_reset(1'b0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("bp_w3_req", {31'b0, imem_req}, 32'd0);
    drive(0, 0, 0, 0);
    chk("bp_w4_req", {31'b0, imem_req}, 32'd0);
    drive(0, 0, 0, 0);
    chk("bp_w5_req", {31'b0, imem_req}, 32'd0);
    chk("bp_w5_valid", {31'b0, ir_valid}, 32'd1);
    chk("bp_w5_pc", ir_pc, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      chk("bp_rel_valid", {31'b0, ir_valid}, 32'd1);
      chk("bp_rel_pc", ir_pc, 32'(4 * k));
      chk("bp_rel_ir", ir, memf(32'(4 * k)));
    end

    // Redirect with a buffered entry and a request in flight
    do_reset(1'b0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 32'h0000_0100, 0);
    chk("rd_req_n", {31'b0, imem_req}, 32'd0);
    drive(0, 0, 0, 0);
    chk("rd_valid_n1", {31'b0, ir_valid}, 32'd0);
    chk("rd_req_n1", {31'b0, imem_req}, 32'd1);
    chk("rd_addr_n1", imem_addr, 32'h100);
    drive(0, 0, 0, 0);
    chk("rd_valid_n2", {31'b0, ir_valid}, 32'd0);
    drive(0, 0, 0, 0);
    chk("rd_valid_n3", {31'b0, ir_valid}, 32'd1);
    chk("rd_pc_n3", ir_pc, 32'h100);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      chk("rd_stream_pc", ir_pc, 32'h100 + 32'(4 * k));
      chk("rd_stream_ir", ir, memf(32'h100 + 32'(4 * k)));
    end

    // Table of redirect targets applied to a running stream
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, rtab[i].rpc, 1);
      chk("tab_req_n", {31'b0, imem_req}, 32'd0);
      drive(0, 0, 0, 1);
      chk("tab_misalign", {31'b0, misalign}, {31'b0, rtab[i].exp_mis});
      chk("tab_valid_n1", {31'b0, ir_valid}, 32'd0);
      chk("tab_addr_n1", imem_addr, rtab[i].exp_pc);
      drive(0, 0, 0, 1);
      chk("tab_mis_clear", {31'b0, misalign}, 32'd0);
      chk("tab_valid_n2", {31'b0, ir_valid}, 32'd0);
      drive(0, 0, 0, 1);
      chk("tab_valid_n3", {31'b0, ir_valid}, 32'd1);
      chk("tab_pc_n3", ir_pc, rtab[i].exp_pc);
      chk("tab_ir_n3", ir, memf(rtab[i].exp_pc));
      drive(0, 0, 0, 1);
      chk("tab_pc_n4", ir_pc, rtab[i].exp_next);
    end

    // Stall for three cycles with a request in flight
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    chk("st_w5_req", {31'b0, imem_req}, 32'd0);
    chk("st_w5_pc", ir_pc, 32'd8);
    drive(1, 0, 0, 1);
    chk("st_w6_req", {31'b0, imem_req}, 32'd0);
    chk("st_w6_valid", {31'b0, ir_valid}, 32'd1);
    chk("st_w6_pc", ir_pc, 32'd12);
    drive(1, 0, 0, 1);
    chk("st_w7_req", {31'b0, imem_req}, 32'd0);
    chk("st_w7_valid", {31'b0, ir_valid}, 32'd0);
    chk("st_w7_addr", imem_addr, 32'd16);
    drive(0, 0, 0, 1);
    chk("st_w8_req", {31'b0, imem_req}, 32'd1);
    chk("st_w8_addr", imem_addr, 32'd16);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("st_w10_pc", ir_pc, 32'd16);
    chk("st_w10_ir", ir, memf(32'd16));

    // Reset asserted in the middle of a cycle while streaming
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, ir_valid}, 32'd0);
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    chk("mr_ir_pc", ir_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    drive(0, 0, 0, 1);
    chk("mr_w1_addr", imem_addr, 32'd0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("mr_w3_pc", ir_pc, 32'd0);
    chk("mr_w3_valid", {31'b0, ir_valid}, 32'd1);

    // Random traffic against a stream-level reference model: delivered PCs
    // form a consecutive word sequence that restarts at each redirect target.
    do_reset(1'b1);
    exp_pc = 32'h0;
    exp_mis = 1'b0;
    expect_empty = 1'b0;
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      st  = ($urandom % 4) == 0;
      rv  = ($urandom % 16) == 0;
      rpc = $urandom & 32'h0000_FFFF;
      rdy = ($urandom % 10) < 7;
      drive(st, rv, rpc, rdy);
      chk("rnd_misalign", {31'b0, misalign}, {31'b0, exp_mis});
      if (expect_empty) chk("rnd_flush", {31'b0, ir_valid}, 32'd0);
      if (st || rv) chk("rnd_req_blocked", {31'b0, imem_req}, 32'd0);
      if (imem_req) chk("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (ir_valid && rdy && !rv) begin
        chk("rnd_pc", ir_pc, exp_pc);
        chk("rnd_ir", ir, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      exp_mis = rv && (rpc[1:0] != 2'b00);
      expect_empty = rv;
      if (rv) exp_pc = {rpc[31:2], 2'b00};
    end
    n_checks++;
    if (delivered < 400) begin
      n_fail++;
      $display("FAIL rnd_progress: got %0d deliveries expected at least 400", delivered);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
